// File: rtl/rx_intf_m_axis_streamer_pkg.sv
// rtl/rx_intf_m_axis_streamer_pkg.sv - shared state encoding and default sizes for the rx m_axis streamer
package rx_intf_m_axis_streamer_pkg;

   localparam int DEF_TDATA_WIDTH = 64;
   localparam int DEF_NUM_WIDTH   = 14;
   localparam int DEF_FIFO_AW     = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_RECOVER = 2'd2
   } stream_state_t;

endpackage

// File: rtl/rx_intf_sync_fifo.sv
// rtl/rx_intf_sync_fifo.sv - first-word-fall-through FIFO with occupancy count and synchronous flush
module rx_intf_sync_fifo #(
   parameter int DW = 64,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          wr_drop
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_rd;
   logic          do_wr;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty && !flush;
   // a pop in the same cycle frees a slot, so a write at full is still accepted
   assign do_wr   = wr_en && !flush && (!full || do_rd);
   assign wr_drop = wr_en && !flush && full && !do_rd;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/rx_intf_m_axis_streamer.sv
// rtl/rx_intf_m_axis_streamer.sv - buffers rx words and streams num_dma_symbol beats per start to the DMA S2MM port
// Optional RX_INTF_M_AXIS_STAT_EN adds saturating packet/recover/drop counters.
module rx_intf_m_axis_streamer
   import rx_intf_m_axis_streamer_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
   parameter int MAX_BIT_NUM_DMA_SYMBOL = DEF_NUM_WIDTH,
   parameter int FIFO_ADDR_WIDTH        = DEF_FIFO_AW
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                m_axis_rst,
   input  logic                                m_axis_tlast_auto_recover,
   input  logic                                start_1trans,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_dma_symbol,
   input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   data_in,
   input  logic                                data_in_valid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic                                m_axis_tlast,
   output logic                                m_axis_tlast_done,
   output logic [FIFO_ADDR_WIDTH:0]            fifo_data_count,
   output logic                                fifo_overflow
`ifdef RX_INTF_M_AXIS_STAT_EN
   ,output logic [31:0]                        pkt_done_cnt
   ,output logic [15:0]                        recover_cnt
   ,output logic [15:0]                        drop_word_cnt
`endif
);

   stream_state_t                       state;
   stream_state_t                       next_state;
   logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_reg;
   logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_cnt;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0]   fifo_head;
   logic                                fifo_empty;
   logic                                fifo_drop;
   logic                                fifo_rd;
   logic                                fifo_flush;
   logic                                recover_entry;
   logic                                abort;
   logic                                handshake;
   logic                                hs_last;

   // auto_recover is only honoured outside RECOVER; it outranks m_axis_rst
   assign recover_entry = m_axis_tlast_auto_recover && (state != ST_RECOVER);
   assign abort         = m_axis_rst || recover_entry;
   assign fifo_flush    = abort;
   assign handshake     = m_axis_tvalid && m_axis_tready;
   assign hs_last       = handshake && m_axis_tlast;
   assign fifo_rd       = (state == ST_STREAM) && handshake;

   rx_intf_sync_fifo #(
      .DW (C_M00_AXIS_TDATA_WIDTH),
      .AW (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (fifo_flush),
      .wr_en   (data_in_valid),
      .wr_data (data_in),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .count   (fifo_data_count),
      .empty   (fifo_empty),
      .wr_drop (fifo_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (recover_entry) begin
         next_state = ST_RECOVER;
      end else if (m_axis_rst) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start_1trans && (num_dma_symbol != '0)) next_state = ST_STREAM;
            ST_STREAM:  if (hs_last) next_state = ST_IDLE;
            ST_RECOVER: if (m_axis_tready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = fifo_head;
      m_axis_tkeep  = '1;
      case (state)
         ST_STREAM: begin
            m_axis_tvalid = !fifo_empty;
            m_axis_tlast  = (beat_cnt == num_reg - 1'b1);
         end
         ST_RECOVER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tdata  = '0;
         end
         default: begin
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_reg           <= '0;
         beat_cnt          <= '0;
         m_axis_tlast_done <= 1'b0;
         fifo_overflow     <= 1'b0;
      end else begin
         m_axis_tlast_done <= hs_last && !abort;
         if (m_axis_rst)     fifo_overflow <= 1'b0;
         else if (fifo_drop) fifo_overflow <= 1'b1;
         if ((state == ST_IDLE) && start_1trans && !abort) begin
            num_reg  <= num_dma_symbol;
            beat_cnt <= '0;
         end else if (fifo_rd) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

`ifdef RX_INTF_M_AXIS_STAT_EN
   logic pkt_inc;
   logic rec_inc;

   assign pkt_inc = hs_last && (state == ST_STREAM) && !abort;
   assign rec_inc = hs_last && (state == ST_RECOVER) && !abort;

   // statistics survive m_axis_rst so software can read them after a flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_done_cnt  <= '0;
         recover_cnt   <= '0;
         drop_word_cnt <= '0;
      end else begin
         if (pkt_inc && (pkt_done_cnt != '1))    pkt_done_cnt  <= pkt_done_cnt + 1'b1;
         if (rec_inc && (recover_cnt != '1))     recover_cnt   <= recover_cnt + 1'b1;
         if (fifo_drop && (drop_word_cnt != '1)) drop_word_cnt <= drop_word_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_intf_m_axis_streamer.sv
// tb/tb_rx_intf_m_axis_streamer.sv - scoreboard bench for rx_intf_m_axis_streamer
module tb_rx_intf_m_axis_streamer;

   localparam int DW    = 64;
   localparam int NW    = 14;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic            clk = 1'b0;
   logic            rst;
   logic            m_axis_rst;
   logic            auto_rec;
   logic            start;
   logic [NW-1:0]   num;
   logic [DW-1:0]   din;
   logic            din_valid;
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic            tvalid;
   logic            tready;
   logic            tlast;
   logic            tlast_done;
   logic [AW:0]     fcount;
   logic            overflow;
`ifdef RX_INTF_M_AXIS_STAT_EN
   logic [31:0]     pkt_done_cnt;
   logic [15:0]     recover_cnt;
   logic [15:0]     drop_word_cnt;
`endif

   always #5 clk = ~clk;

   rx_intf_m_axis_streamer dut (
      .clk                       (clk),
      .rst                       (rst),
      .m_axis_rst                (m_axis_rst),
      .m_axis_tlast_auto_recover (auto_rec),
      .start_1trans              (start),
      .num_dma_symbol            (num),
      .data_in                   (din),
      .data_in_valid             (din_valid),
      .m_axis_tdata              (tdata),
      .m_axis_tkeep              (tkeep),
      .m_axis_tvalid             (tvalid),
      .m_axis_tready             (tready),
      .m_axis_tlast              (tlast),
      .m_axis_tlast_done         (tlast_done),
      .fifo_data_count           (fcount),
      .fifo_overflow             (overflow)
`ifdef RX_INTF_M_AXIS_STAT_EN
      ,.pkt_done_cnt             (pkt_done_cnt)
      ,.recover_cnt              (recover_cnt)
      ,.drop_word_cnt            (drop_word_cnt)
`endif
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t sb[$];
   int    total = 0;
   int    bad = 0;
   int    ready_pct = 100;
   int    exp_pkts = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = ($urandom_range(99) < ready_pct);
      end
   end

   // monitor: pops the scoreboard on every handshake, checks stall stability and tlast_done timing
   logic          prev_last_hs = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_tlast;
   beat_t         mon_b;

   always @(negedge clk) begin
      if (rst) begin
         prev_last_hs = 1'b0;
         prev_stall   = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", tvalid, 1);
            chk("stall_data", tdata, prev_data);
            chk("stall_last", tlast, prev_tlast);
         end
         if (prev_last_hs || tlast_done) chk("tlast_done", tlast_done, prev_last_hs);
         if (tvalid && tready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data %0h with nothing expected", tdata);
            end else begin
               mon_b = sb.pop_front();
               chk("beat_data", tdata, mon_b.data);
               chk("beat_last", tlast, mon_b.last);
            end
         end
         prev_last_hs = tvalid && tready && tlast && !m_axis_rst;
         prev_stall   = tvalid && !tready && !m_axis_rst && !auto_rec;
         prev_data    = tdata;
         prev_tlast   = tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d, input bit expect_out, input bit last);
      din       = d;
      din_valid = 1'b1;
      if (expect_out) sb.push_back('{d, last});
      tick();
      din_valid = 1'b0;
   endtask

   task automatic start_pkt(input int n);
      start = 1'b1;
      num   = NW'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 4000 && sb.size() != 0; i++) tick();
      chk(name, sb.size(), 0);
      repeat (2) tick();
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic packet(input int n, input bit start_first);
      if (!start_first) begin
         for (int i = 0; i < n; i++) write_word(rnd64(), 1, i == n - 1);
         chk("pre_start_count", fcount, n);
         start_pkt(n);
      end else begin
         start_pkt(n);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            write_word(rnd64(), 1, i == n - 1);
         end
      end
      exp_pkts++;
      wait_drain("drain_packet");
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] w;
      rst        = 1'b1;
      m_axis_rst = 1'b0;
      auto_rec   = 1'b0;
      start      = 1'b0;
      num        = '0;
      din        = '0;
      din_valid  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tlast_done", tlast_done, 0);
      chk("rst_count", fcount, 0);
      chk("rst_overflow", overflow, 0);
      chk("tkeep", tkeep, 8'hFF);

      ready_pct = 100;
      packet(4, 0);
      ready_pct = 50;
      packet(4, 0);

      for (int k = 0; k < 12; k++) begin
         ready_pct = $urandom_range(30, 100);
         packet($urandom_range(1, 24), bit'($urandom_range(0, 1)));
      end

      // underrun then single word: visible the cycle after it is written
      ready_pct = 0;
      start_pkt(1);
      repeat (3) tick();
      chk("underrun_tvalid", tvalid, 0);
      w = rnd64();
      write_word(w, 1, 1);
      chk("latency_tvalid", tvalid, 1);
      chk("latency_tdata", tdata, w);
      chk("latency_tlast", tlast, 1);
      ready_pct = 100;
      exp_pkts++;
      wait_drain("drain_latency");

      // num=0 produces nothing; the buffered word goes out with the next num=1
      start_pkt(0);
      write_word(rnd64(), 1, 1);
      repeat (4) tick();
      chk("num0_tvalid", tvalid, 0);
      chk("num0_count", fcount, 1);
      start_pkt(1);
      exp_pkts++;
      wait_drain("drain_num1");

      // full FIFO: a write in the same cycle as a pop is accepted
      ready_pct = 100;
      for (int i = 0; i < DEPTH; i++) write_word(rnd64(), 1, 0);
      chk("full_count", fcount, DEPTH);
      chk("full_no_overflow", overflow, 0);
      start_pkt(DEPTH + 1);
      write_word(rnd64(), 1, 1);
      chk("full_rw_count", fcount, DEPTH);
      chk("full_rw_overflow", overflow, 0);
      exp_pkts++;
      wait_drain("drain_full");

      // overflow: 3 writes dropped, sticky flag, cleared by m_axis_rst
      ready_pct = 0;
      for (int i = 0; i < DEPTH + 3; i++) write_word(rnd64(), 0, 0);
      chk("ovf_count", fcount, DEPTH);
      chk("ovf_flag", overflow, 1);
`ifdef RX_INTF_M_AXIS_STAT_EN
      chk("drop_word_cnt", drop_word_cnt, 3);
`endif
      m_axis_rst = 1'b1;
      tick();
      m_axis_rst = 1'b0;
      chk("mrst_count", fcount, 0);
      chk("mrst_overflow", overflow, 0);
      repeat (2) tick();
      chk("mrst_tvalid", tvalid, 0);

      // recover with a simultaneous soft reset mid-packet
      ready_pct = 100;
      start_pkt(6);
      write_word(rnd64(), 1, 0);
      write_word(rnd64(), 1, 0);
      repeat (3) tick();
      chk("rec_underrun", tvalid, 0);
      m_axis_rst = 1'b1;
      auto_rec   = 1'b1;
      sb.push_back('{'0, 1'b1});
      tick();
      m_axis_rst = 1'b0;
      auto_rec   = 1'b0;
      chk("rec_count", fcount, 0);
      chk("rec_tvalid", tvalid, 1);
      wait_drain("drain_recover");
      chk("post_rec_tvalid", tvalid, 0);
`ifdef RX_INTF_M_AXIS_STAT_EN
      chk("recover_cnt", recover_cnt, 1);
      chk("pkt_done_cnt", pkt_done_cnt, exp_pkts);
`endif

      // hard reset on beat 2 of 5
      for (int i = 0; i < 5; i++) write_word(rnd64(), 1, i == 4);
      start_pkt(5);
      for (int i = 0; i < 200 && sb.size() > 3; i++) tick();
      chk("mid_beats_left", sb.size(), 3);
      rst = 1'b1;
      #1;
      chk("rst_mid_tvalid", tvalid, 0);
      chk("rst_mid_count", fcount, 0);
      sb.delete();
      tick();
      rst = 1'b0;
      tick();
      exp_pkts = 0;
      ready_pct = 60;
      packet(3, 0);
`ifdef RX_INTF_M_AXIS_STAT_EN
      chk("pkt_done_after_rst", pkt_done_cnt, exp_pkts);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
